fetch_stage: RTL and testbench

//  Instruction-fetch stage feeding the IF/ID pipeline register. Owns the PC, issues reads to a

---
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC and issues one outstanding read at a time to a multi-cycle
// instruction memory. It holds the returned word while the pipeline is stalled, squashes
// words made stale by a branch/jump redirect, and parks on HALT until redirected.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall_disable,
  input  logic        Redirect,
  input  logic [15:0] Redirect_PC,
  input  logic [15:0] imem_data_out,
  input  logic        imem_done,
  input  logic        imem_err,
  output logic [15:0] imem_addr,
  output logic        imem_rd,
  output logic [15:0] Instruction_IF_out,
  output logic [15:0] PCplus2_IF_out,
  output logic        CreateDump_IF_out,
  output logic        Err_IF_out,
  output logic        Fetch_valid,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic        squash;
  logic [15:0] pc_next_seq;
  logic        fetched_halt;

  // Sequential successor of the PC; 16-bit wrap from 16'hFFFE to 16'h0000 is intended.
  assign pc_next_seq  = pc + 16'd2;
  assign fetched_halt = (imem_data_out[15:11] == HALT_OPCODE);

  // Read request is issued from REQ only; it is held off during reset and during a redirect so
  // a read at the stale PC is never launched and only one request is ever outstanding.
  assign imem_rd   = (state == ST_REQ) && !rst && !Redirect;
  assign imem_addr = pc;

  // Fetch FSM, PC and IF/ID-facing output registers, all updated together on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_REQ;
      pc                 <= RESET_PC;
      squash             <= 1'b0;
      Fetch_valid        <= 1'b0;
      Instruction_IF_out <= NOP_INSTR;
      PCplus2_IF_out     <= 16'h0000;
      CreateDump_IF_out  <= 1'b0;
      Err_IF_out         <= 1'b0;
      err                <= 1'b0;
    end else begin
      err <= 1'b0;

      if (Fetch_valid && !Stall_disable) begin
        Fetch_valid        <= 1'b0;
        Instruction_IF_out <= NOP_INSTR;
        CreateDump_IF_out  <= 1'b0;
        Err_IF_out         <= 1'b0;
      end

      if (Redirect) begin
        pc                 <= Redirect_PC;
        Fetch_valid        <= 1'b0;
        Instruction_IF_out <= NOP_INSTR;
        CreateDump_IF_out  <= 1'b0;
        Err_IF_out         <= 1'b0;
        if ((state == ST_WAIT) && !imem_done) begin
          squash <= 1'b1;
        end else begin
          squash <= 1'b0;
          state  <= ST_REQ;
        end
      end else begin
        case (state)
          ST_REQ: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (imem_done) begin
              if (squash) begin
                squash <= 1'b0;
                state  <= ST_REQ;
              end else begin
                Fetch_valid        <= 1'b1;
                Instruction_IF_out <= imem_data_out;
                Err_IF_out         <= imem_err;
                PCplus2_IF_out     <= pc_next_seq;
                if (fetched_halt) begin
                  CreateDump_IF_out <= 1'b1;
                  state             <= ST_HALTED;
                end else if (Stall_disable) begin
                  CreateDump_IF_out <= 1'b0;
                  state             <= ST_HOLD;
                end else begin
                  CreateDump_IF_out <= 1'b0;
                  pc                <= pc_next_seq;
                  state             <= ST_REQ;
                end
              end
            end
          end
          ST_HOLD: begin
            if (!Stall_disable) begin
              pc    <= pc_next_seq;
              state <= ST_REQ;
            end
          end
          ST_HALTED: begin
            state <= ST_HALTED;
          end
          default: begin
            err   <= 1'b1;
            state <= ST_REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus a randomized stream checked against a
// transaction-level model of the fetch contract (request order, one outstanding read,
// word-to-output latency, stall hold, redirect squash).
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall_disable;
  logic        Redirect;
  logic [15:0] Redirect_PC;
  logic [15:0] imem_data_out;
  logic        imem_done;
  logic        imem_err;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic [15:0] Instruction_IF_out;
  logic [15:0] PCplus2_IF_out;
  logic        CreateDump_IF_out;
  logic        Err_IF_out;
  logic        Fetch_valid;
  logic        err;

  int checks   = 0;
  int failures = 0;

  // Memory model state: one pending response, latency counted in cycles after the request.
  int          countdown = 0;
  int          mem_lat   = 1;
  bit          rand_lat  = 1'b0;
  logic [16:0] script_q[$];
  logic [15:0] pend_word;
  logic        pend_err;

  fetch_stage #(
    .RESET_PC   (16'h0000),
    .NOP_INSTR  (16'h0800),
    .HALT_OPCODE(5'b00000)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .Stall_disable     (Stall_disable),
    .Redirect          (Redirect),
    .Redirect_PC       (Redirect_PC),
    .imem_data_out     (imem_data_out),
    .imem_done         (imem_done),
    .imem_err          (imem_err),
    .imem_addr         (imem_addr),
    .imem_rd           (imem_rd),
    .Instruction_IF_out(Instruction_IF_out),
    .PCplus2_IF_out    (PCplus2_IF_out),
    .CreateDump_IF_out (CreateDump_IF_out),
    .Err_IF_out        (Err_IF_out),
    .Fetch_valid       (Fetch_valid),
    .err               (err)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Memory response driver: counts down after each request and pulses done for one cycle.
  initial begin
    imem_done     = 1'b0;
    imem_err      = 1'b0;
    imem_data_out = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      imem_done = 1'b0;
      imem_err  = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          imem_done     = 1'b1;
          imem_data_out = pend_word;
          imem_err      = pend_err;
        end
      end
    end
  end

  // Memory request capture: samples imem_rd mid-cycle and books the response word.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_rd === 1'b1) begin
        countdown = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
        if (script_q.size() > 0) begin
          {pend_err, pend_word} = script_q.pop_front();
        end else begin
          pend_word = {5'($urandom_range(1, 31)), 11'($urandom)};
          pend_err  = ($urandom_range(0, 7) == 0);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout want=finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] time limit reached");
  end

  function automatic logic [49:0] snap();
    return {Fetch_valid, Instruction_IF_out, PCplus2_IF_out, imem_rd, imem_addr};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Stall_disable = 1'b0;
    Redirect      = 1'b0;
    Redirect_PC   = 16'h0000;
    countdown     = 0;
    rand_lat      = 1'b0;
    mem_lat       = 1;
    script_q.delete();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [22:0] got, want;
    rst = 1'b1;
    cyc();
    @(negedge clk);
    got  = {Fetch_valid, Instruction_IF_out, CreateDump_IF_out, Err_IF_out, imem_rd, err, 1'b0};
    want = {1'b0, NOP, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL reset_outputs got=%h want=%h", got, want);
    end
    checks++;
    if (PCplus2_IF_out !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_pcplus2 got=%h want=0000", PCplus2_IF_out);
    end
    cyc();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({imem_rd, imem_addr} !== {1'b1, 16'h0000}) begin
      failures++;
      $display("[TB] FAIL reset_first_req got=%b/%h want=1/0000", imem_rd, imem_addr);
    end
  endtask

  task automatic test_basic();
    logic [49:0] want;
    do_reset();
    script_q.push_back(17'h04001);
    script_q.push_back(17'h04002);
    want = {1'b0, NOP, 16'h0000, 1'b1, 16'h0000};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL basic_c0 got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b0, NOP, 16'h0000, 1'b0, 16'h0000};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL basic_c1 got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b1, 16'h4001, 16'h0002, 1'b1, 16'h0002};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL basic_c2 got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b0, NOP, 16'h0002, 1'b0, 16'h0002};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL basic_c3 got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b1, 16'h4002, 16'h0004, 1'b1, 16'h0004};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL basic_c4 got=%h want=%h", snap(), want); end
  endtask

  task automatic test_stall();
    logic [49:0] want;
    do_reset();
    script_q.push_back(17'h04001);
    script_q.push_back(17'h04002);
    cyc();
    Stall_disable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) Stall_disable = 1'b0;
      want = {1'b1, 16'h4001, 16'h0002, 1'b0, 16'h0000};
      @(negedge clk); checks++;
      if (snap() !== want) begin failures++; $display("[TB] FAIL stall_hold%0d got=%h want=%h", k, snap(), want); end
    end
    cyc();
    want = {1'b0, NOP, 16'h0002, 1'b1, 16'h0002};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL stall_release got=%h want=%h", snap(), want); end
    cyc();
    cyc();
    want = {1'b1, 16'h4002, 16'h0004, 1'b1, 16'h0004};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL stall_next got=%h want=%h", snap(), want); end
  endtask

  task automatic test_redirect_squash();
    logic [49:0] want;
    do_reset();
    mem_lat = 3;
    script_q.push_back(17'h04001);
    script_q.push_back(17'h04003);
    cyc();
    Redirect    = 1'b1;
    Redirect_PC = 16'h0100;
    cyc();
    Redirect = 1'b0;
    want = {1'b0, NOP, 16'h0000, 1'b0, 16'h0100};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL squash_wait got=%h want=%h", snap(), want); end
    cyc();
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL squash_stale_done got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b0, NOP, 16'h0000, 1'b1, 16'h0100};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL squash_new_req got=%h want=%h", snap(), want); end
    repeat (4) cyc();
    want = {1'b1, 16'h4003, 16'h0102, 1'b1, 16'h0102};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL squash_target_word got=%h want=%h", snap(), want); end
  endtask

  task automatic test_halt();
    logic [49:0] want;
    do_reset();
    script_q.push_back(17'h00000);
    script_q.push_back(17'h04010);
    cyc();
    cyc();
    want = {1'b1, 16'h0000, 16'h0002, 1'b0, 16'h0000};
    @(negedge clk); checks++;
    if ({snap(), CreateDump_IF_out} !== {want, 1'b1}) begin
      failures++; $display("[TB] FAIL halt_word got=%h/%b want=%h/1", snap(), CreateDump_IF_out, want);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (k == 2) begin
        Redirect    = 1'b1;
        Redirect_PC = 16'h0020;
      end
      want = {1'b0, NOP, 16'h0002, 1'b0, 16'h0000};
      @(negedge clk); checks++;
      if ({snap(), CreateDump_IF_out} !== {want, 1'b0}) begin
        failures++; $display("[TB] FAIL halt_parked%0d got=%h/%b want=%h/0", k, snap(), CreateDump_IF_out, want);
      end
    end
    cyc();
    Redirect = 1'b0;
    want = {1'b0, NOP, 16'h0002, 1'b1, 16'h0020};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL halt_resume got=%h want=%h", snap(), want); end
    cyc();
    cyc();
    want = {1'b1, 16'h4010, 16'h0022, 1'b1, 16'h0022};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL halt_resume_word got=%h want=%h", snap(), want); end
  endtask

  task automatic test_wrap();
    logic [49:0] want;
    do_reset();
    script_q.push_back(17'h04004);
    script_q.push_back(17'h04005);
    cyc();
    Redirect    = 1'b1;
    Redirect_PC = 16'hFFFE;
    want = {1'b0, NOP, 16'h0000, 1'b0, 16'h0000};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL wrap_redirect_done got=%h want=%h", snap(), want); end
    cyc();
    Redirect = 1'b0;
    want = {1'b0, NOP, 16'h0000, 1'b1, 16'hFFFE};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL wrap_req got=%h want=%h", snap(), want); end
    cyc();
    cyc();
    want = {1'b1, 16'h4005, 16'h0000, 1'b1, 16'h0000};
    @(negedge clk); checks++;
    if ({snap(), err} !== {want, 1'b0}) begin
      failures++; $display("[TB] FAIL wrap_word got=%h/%b want=%h/0", snap(), err, want);
    end
  endtask

  task automatic test_err_and_reset();
    logic [49:0] want;
    do_reset();
    script_q.push_back(17'h14006);
    script_q.push_back(17'h04007);
    script_q.push_back(17'h04009);
    script_q.push_back(17'h04008);
    cyc();
    cyc();
    want = {1'b1, 16'h4006, 16'h0002, 1'b1, 16'h0002};
    @(negedge clk); checks++;
    if ({snap(), Err_IF_out} !== {want, 1'b1}) begin
      failures++; $display("[TB] FAIL err_flagged got=%h/%b want=%h/1", snap(), Err_IF_out, want);
    end
    cyc();
    want = {1'b0, NOP, 16'h0002, 1'b0, 16'h0002};
    @(negedge clk); checks++;
    if ({snap(), Err_IF_out} !== {want, 1'b0}) begin
      failures++; $display("[TB] FAIL err_cleared got=%h/%b want=%h/0", snap(), Err_IF_out, want);
    end
    mem_lat = 2;
    cyc();
    want = {1'b1, 16'h4007, 16'h0004, 1'b1, 16'h0004};
    @(negedge clk); checks++;
    if ({snap(), Err_IF_out} !== {want, 1'b0}) begin
      failures++; $display("[TB] FAIL err_next_clean got=%h/%b want=%h/0", snap(), Err_IF_out, want);
    end
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    want = {1'b0, NOP, 16'h0000, 1'b1, 16'h0000};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL rst_midwait_req got=%h want=%h", snap(), want); end
    cyc();
    want = {1'b0, NOP, 16'h0000, 1'b0, 16'h0000};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL rst_stale_ignored got=%h want=%h", snap(), want); end
    cyc();
    cyc();
    want = {1'b1, 16'h4008, 16'h0002, 1'b1, 16'h0002};
    @(negedge clk); checks++;
    if (snap() !== want) begin failures++; $display("[TB] FAIL rst_first_word got=%h want=%h", snap(), want); end
  endtask

  // Randomized stream: the model tracks what the fetch contract promises, not how the FSM gets there.
  task automatic test_random_stream();
    logic [15:0] exp_addr, last_req, cur_word, cur_p2, arr_word, arr_p2;
    logic        cur_err, arr_err;
    bit          outstanding, squash_m, holding, mvalid;
    int          kind, nkind, idle, arrivals;
    do_reset();
    rand_lat    = 1'b1;
    exp_addr    = 16'h0000;
    last_req    = 16'h0000;
    cur_word    = NOP;
    cur_p2      = 16'h0000;
    cur_err     = 1'b0;
    arr_word    = NOP;
    arr_p2      = 16'h0000;
    arr_err     = 1'b0;
    outstanding = 1'b0;
    squash_m    = 1'b0;
    holding     = 1'b0;
    kind        = 0;
    idle        = 0;
    arrivals    = 0;
    for (int cyc_i = 0; cyc_i < 600; cyc_i++) begin
      Stall_disable = ($urandom_range(0, 2) == 0);
      Redirect      = ($urandom_range(0, 9) == 0);
      Redirect_PC   = 16'($urandom);
      @(negedge clk);
      if (kind == 2) begin
        cur_word = arr_word;
        cur_p2   = arr_p2;
        cur_err  = arr_err;
      end
      checks++;
      if (kind != 0) begin
        if ({Fetch_valid, Instruction_IF_out, PCplus2_IF_out, Err_IF_out, CreateDump_IF_out} !==
            {1'b1, cur_word, cur_p2, cur_err, 1'b0}) begin
          failures++;
          $display("[TB] FAIL rand_output cyc=%0d got=%b/%h/%h/%b want=1/%h/%h/%b", cyc_i,
                   Fetch_valid, Instruction_IF_out, PCplus2_IF_out, Err_IF_out, cur_word, cur_p2, cur_err);
        end
      end else begin
        if ({Fetch_valid, Instruction_IF_out, CreateDump_IF_out, Err_IF_out} !== {1'b0, NOP, 1'b0, 1'b0}) begin
          failures++;
          $display("[TB] FAIL rand_nop cyc=%0d got=%b/%h want=0/%h", cyc_i, Fetch_valid, Instruction_IF_out, NOP);
        end
      end
      checks++;
      if (err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL rand_err cyc=%0d got=%b want=0", cyc_i, err);
      end
      mvalid = (kind != 0);
      idle++;
      if (imem_rd === 1'b1) begin
        checks++;
        if (holding || outstanding || (imem_addr !== exp_addr)) begin
          failures++;
          $display("[TB] FAIL rand_req cyc=%0d got=%h hold=%b outst=%b want=%h", cyc_i, imem_addr,
                   holding, outstanding, exp_addr);
        end
        outstanding = 1'b1;
        last_req    = exp_addr;
        exp_addr    = exp_addr + 16'd2;
        idle        = 0;
      end
      if (holding && !Stall_disable) holding = 1'b0;
      nkind = (mvalid && Stall_disable) ? 1 : 0;
      if (imem_done === 1'b1) begin
        outstanding = 1'b0;
        idle        = 0;
        if (Redirect || squash_m) begin
          squash_m = 1'b0;
        end else begin
          nkind    = 2;
          arr_word = imem_data_out;
          arr_err  = imem_err;
          arr_p2   = last_req + 16'd2;
          arrivals++;
          holding  = Stall_disable;
        end
      end
      if (Redirect) begin
        nkind    = 0;
        exp_addr = Redirect_PC;
        holding  = 1'b0;
        if (outstanding) squash_m = 1'b1;
      end
      if (holding) idle = 0;
      checks++;
      if (idle > 30) begin
        failures++;
        $display("[TB] FAIL rand_progress cyc=%0d got=idle%0d want=activity", cyc_i, idle);
        idle = 0;
      end
      kind = nkind;
      cyc();
    end
    Stall_disable = 1'b0;
    Redirect      = 1'b0;
    checks++;
    if (arrivals < 40) begin
      failures++;
      $display("[TB] FAIL rand_throughput got=%0d want>=40", arrivals);
    end
  endtask

  // Test sequence and summary.
  initial begin
    rst           = 1'b1;
    Stall_disable = 1'b0;
    Redirect      = 1'b0;
    Redirect_PC   = 16'h0000;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_squash();
    test_halt();
    test_wrap();
    test_err_and_reset();
    test_random_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
